hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the in-order RISC-V pipeline, generalising the single-cycle forwarding/stall/flush logic with a register scoreboard for variable-latency units such as the iterative divider. It sits beside the pipeline registers and drives the fetch/decode enables, the decode/execute flushes and the execute-stage forwarding muxes. Long ops leave the pipeline at E, complete out of order and write the register file directly. Decode is held until every source and destination register it uses is no longer pending.

---
 rtl/hazard_scoreboard.sv | 185 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Hazard unit for an in-order five-stage RISC-V pipeline. It provides
// single-cycle forwarding, load-use stalls and branch flushes. A register
// scoreboard holds decode while any register it reads or writes is still
// owned by a variable-latency unit, such as the iterative divider.
//
// Long-op protocol: long_issue_e and long_done are single-cycle strobes
// with no backpressure. An issue is accepted on the rising edge of every
// cycle in which long_issue_e is high, rd_e != 0 and fewer than MAXOUT ops
// are in flight. A completion is accepted on every cycle in which long_done
// is high and long_rd_done is a pending register. Any other completion sets
// the sticky sb_err flag and changes no other state.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d          decode-stage sources / destination
//   regwrite_d, long_d          decode writes rd / decode is a long op
//   rs1_e, rs2_e, rd_e          execute-stage registers
//   load_e                      execute instruction is a load
//   long_issue_e                execute instruction dispatched to a long unit
//   rd_m, regwrite_m            memory-stage destination / write enable
//   rd_w, regwrite_w            writeback-stage destination / write enable
//   pcsrc_e                     taken branch/jump resolved in execute
//   long_done, long_rd_done     long unit writes long_rd_done this cycle
//   stall_f, stall_d            fetch/decode hold
//   flush_d, flush_e            decode/execute bubble insertion
//   forwarda, forwardb          00 regfile, 10 from M, 01 from W
//   pending                     scoreboard bits (bit 0 always 0)
//   outstanding                 long ops in flight
//   sb_err                      sticky: completion for a non-pending register

module hazard_scoreboard #(
    parameter  int NREG   = 32,
    parameter  int MAXOUT = 4,
    localparam int AW     = $clog2(NREG),
    localparam int OW     = $clog2(MAXOUT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_d,
    input  logic [AW-1:0]   rs2_d,
    input  logic [AW-1:0]   rd_d,
    input  logic            regwrite_d,
    input  logic            long_d,
    input  logic [AW-1:0]   rs1_e,
    input  logic [AW-1:0]   rs2_e,
    input  logic [AW-1:0]   rd_e,
    input  logic            load_e,
    input  logic            long_issue_e,
    input  logic [AW-1:0]   rd_m,
    input  logic [AW-1:0]   rd_w,
    input  logic            regwrite_m,
    input  logic            regwrite_w,
    input  logic            pcsrc_e,
    input  logic            long_done,
    input  logic [AW-1:0]   long_rd_done,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic [1:0]      forwarda,
    output logic [1:0]      forwardb,
    output logic [NREG-1:0] pending,
    output logic [OW-1:0]   outstanding,
    output logic            sb_err
);

    // Looks up one bit of a register-indexed vector. Indices at or above
    // NREG read as 0, which keeps a non-power-of-two NREG safe.
    function automatic logic bit_at(input logic [NREG-1:0] vec,
                                    input logic [AW-1:0]   idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == AW'(i)) r = vec[i];
        end
        return r;
    endfunction

    // Builds a one-hot vector for a register index. Index 0 never
    // produces a bit, because x0 is never tracked.
    function automatic logic [NREG-1:0] onehot_nz(input logic [AW-1:0] idx);
        logic [NREG-1:0] r;
        r = '0;
        for (int i = 1; i < NREG; i++) begin
            if (idx == AW'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Forwarding select for one execute-stage source. M wins over W.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        logic [1:0] r;
        r = 2'b00;
        if (regwrite_m && (rd_m != '0) && (rd_m == src)) begin
            r = 2'b10;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == src)) begin
            r = 2'b01;
        end
        return r;
    endfunction

    logic [NREG-1:0] pending_q;
    logic [OW-1:0]   outstanding_q;
    logic            sb_err_q;

    logic [NREG-1:0] issue_vec;
    logic [NREG-1:0] done_vec;
    logic [NREG-1:0] pending_view;
    logic            issue_ok;
    logic            done_ok;
    logic            at_cap;
    logic            lwstall;
    logic            sbstall;
    logic            capstall;
    logic            hold;
    logic [NREG-1:0] pending_nxt;
    logic [OW-1:0]   outstanding_nxt;

    // Scoreboard next state
    always_comb begin
        issue_vec       = onehot_nz(rd_e);
        done_vec        = onehot_nz(long_rd_done);
        at_cap          = (outstanding_q == OW'(MAXOUT));
        issue_ok        = long_issue_e && (rd_e != '0) && !at_cap;
        // A completion is valid only for a register that is currently
        // pending. done_vec is zero for x0, so x0 always counts as invalid.
        done_ok         = long_done && ((done_vec & pending_q) != '0);

        // The clear is applied before the set. An issue and a completion
        // on the same register therefore leave the bit set.
        pending_nxt     = pending_q;
        if (done_ok)  pending_nxt = pending_nxt & ~done_vec;
        if (issue_ok) pending_nxt = pending_nxt | issue_vec;

        outstanding_nxt = outstanding_q;
        if (issue_ok && !done_ok) begin
            outstanding_nxt = outstanding_q + OW'(1);
        end else if (done_ok && !issue_ok && (outstanding_q != '0)) begin
            outstanding_nxt = outstanding_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            sb_err_q      <= 1'b0;
        end else begin
            pending_q     <= pending_nxt;
            outstanding_q <= outstanding_nxt;
            if (long_done && !done_ok) sb_err_q <= 1'b1;
        end
    end

    // Stall / flush / forwarding
    always_comb begin
        // A long op in E whose destination is read in D has not set its
        // pending bit yet. Folding the issuing destination in here covers
        // the E-to-D RAW case without waiting a cycle.
        pending_view = pending_q;
        if (long_issue_e) pending_view = pending_view | issue_vec;

        lwstall  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        sbstall  = bit_at(pending_view, rs1_d)
                 || bit_at(pending_view, rs2_d)
                 || (regwrite_d && bit_at(pending_view, rd_d));
        capstall = long_d && at_cap;
        // The instruction in D is discarded on a taken branch, so holding it is pointless.
        hold     = (lwstall || sbstall || capstall) && !pcsrc_e;

        stall_f  = hold;
        stall_d  = hold;
        flush_d  = pcsrc_e;
        flush_e  = hold || pcsrc_e;
        forwarda = fwd_sel(rs1_e);
        forwardb = fwd_sel(rs2_e);
    end

    assign pending     = pending_q;
    assign outstanding = outstanding_q;
    assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NREG   = 32;
    localparam int MAXOUT = 2;
    localparam int AW     = $clog2(NREG);
    localparam int OW     = $clog2(MAXOUT + 1);

    logic clk;
    logic rst_n;
    logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd_done;
    logic regwrite_d, long_d, load_e, long_issue_e, regwrite_m, regwrite_w;
    logic pcsrc_e, long_done;
    logic stall_f, stall_d, flush_d, flush_e, sb_err;
    logic [1:0] forwarda, forwardb;
    logic [NREG-1:0] pending;
    logic [OW-1:0] outstanding;

    hazard_scoreboard #(.NREG(NREG), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .long_d(long_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .long_issue_e(long_issue_e),
        .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .pcsrc_e(pcsrc_e), .long_done(long_done), .long_rd_done(long_rd_done),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forwarda(forwarda), .forwardb(forwardb),
        .pending(pending), .outstanding(outstanding), .sb_err(sb_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: set of pending registers, an in-flight count, a sticky error flag
    bit pend_m [NREG];
    int cnt_m;
    bit err_m;

    logic [63:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic model_reset();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        cnt_m = 0;
        err_m = 1'b0;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] src);
        if (regwrite_m && rd_m != 0 && rd_m == src) return 2'b10;
        if (regwrite_w && rd_w != 0 && rd_w == src) return 2'b01;
        return 2'b00;
    endfunction

    // A register counts as busy if it is in the set, or if a long op
    // targeting it is leaving E in this cycle.
    function automatic bit busy(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        return pend_m[r] || (long_issue_e && rd_e == r);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] exp_v;
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
    endtask

    task automatic chk_const(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        exp_q.push_back(exp_v);
        chk(tag, obs);
    endtask

    // Sample the outputs on the falling edge and compare every output with the model.
    task automatic settle();
        bit lw, sb, cap, hold;
        logic [NREG-1:0] pv;
        @(negedge clk);
        lw   = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        sb   = busy(rs1_d) || busy(rs2_d) || (regwrite_d && busy(rd_d));
        cap  = long_d && cnt_m == MAXOUT;
        hold = (lw || sb || cap) && !pcsrc_e;
        pv   = '0;
        for (int i = 0; i < NREG; i++) pv[i] = pend_m[i];
        exp_q.push_back(64'(hold));
        exp_q.push_back(64'(hold));
        exp_q.push_back(64'(pcsrc_e));
        exp_q.push_back(64'(hold || pcsrc_e));
        exp_q.push_back(64'(fwd_ref(rs1_e)));
        exp_q.push_back(64'(fwd_ref(rs2_e)));
        exp_q.push_back(64'(pv));
        exp_q.push_back(64'(cnt_m));
        exp_q.push_back(64'(err_m));
        chk("stall_f", 64'(stall_f));
        chk("stall_d", 64'(stall_d));
        chk("flush_d", 64'(flush_d));
        chk("flush_e", 64'(flush_e));
        chk("forwarda", 64'(forwarda));
        chk("forwardb", 64'(forwardb));
        chk("pending", 64'(pending));
        chk("outstanding", 64'(outstanding));
        chk("sb_err", 64'(sb_err));
    endtask

    // Apply this cycle's clock-edge effects to the model, then advance past the edge.
    task automatic adv();
        bit done_ok, issue_ok;
        if (rst_n) begin
            done_ok  = long_done && long_rd_done != 0 && pend_m[long_rd_done];
            issue_ok = long_issue_e && rd_e != 0 && cnt_m < MAXOUT;
            if (done_ok) begin
                pend_m[long_rd_done] = 1'b0;
                cnt_m--;
            end else if (long_done) begin
                err_m = 1'b1;
            end
            if (issue_ok) begin
                pend_m[rd_e] = 1'b1;
                cnt_m++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rd_d = 0; regwrite_d = 0; long_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; load_e = 0; long_issue_e = 0;
        rd_m = 0; rd_w = 0; regwrite_m = 0; regwrite_w = 0;
        pcsrc_e = 0; long_done = 0; long_rd_done = 0;
    endtask

    initial begin
        int pl[$];
        // reset state
        idle();
        rst_n = 1'b0;
        model_reset();
        settle();
        chk_const("rst_pending", 64'(pending), 64'd0);
        adv();
        rst_n = 1'b1;
        settle(); adv();

        // forwarding priority
        rd_m = 5; rd_w = 5; regwrite_m = 1; regwrite_w = 1; rs1_e = 5; rs2_e = 0;
        settle();
        chk_const("fwd_prio_a", 64'(forwarda), 64'b10);
        chk_const("fwd_prio_b", 64'(forwardb), 64'b00);
        adv();
        regwrite_m = 0;
        settle();
        chk_const("fwd_w_a", 64'(forwarda), 64'b01);
        adv();
        idle();

        // load-use
        load_e = 1; rd_e = 3; rs2_d = 3;
        settle();
        chk_const("lw_stall", 64'({stall_f, stall_d, flush_e, flush_d}), 64'b1110);
        adv();
        pcsrc_e = 1;
        settle();
        chk_const("lw_branch", 64'({stall_f, stall_d, flush_e, flush_d}), 64'b0011);
        adv();
        idle();

        // scoreboard RAW: issue rd=7 with the consumer already in D
        long_issue_e = 1; rd_e = 7; regwrite_d = 1; rd_d = 2; rs1_d = 7;
        settle();
        chk_const("raw_issue_stall", 64'(stall_d), 64'd1);
        adv();
        long_issue_e = 0; rd_e = 0;
        for (int c = 1; c < 6; c++) begin
            settle();
            chk_const("raw_held", 64'(stall_d), 64'd1);
            adv();
        end
        long_done = 1; long_rd_done = 7;
        settle();
        chk_const("raw_done_cycle", 64'(stall_d), 64'd1);
        adv();
        long_done = 0;
        settle();
        chk_const("raw_release", 64'({pending[7], stall_d}), 64'd0);
        adv();
        idle();

        // WAW
        long_issue_e = 1; rd_e = 9;
        settle(); adv();
        long_issue_e = 0; rd_e = 0; regwrite_d = 1; rd_d = 9;
        settle();
        chk_const("waw_stall", 64'(stall_d), 64'd1);
        adv();
        regwrite_d = 0;
        settle();
        chk_const("waw_nowrite", 64'(stall_d), 64'd0);
        adv();
        regwrite_d = 1; rd_d = 0;
        settle();
        chk_const("waw_x0", 64'(stall_d), 64'd0);
        adv();
        long_done = 1; long_rd_done = 9; rd_d = 9;
        settle(); adv();
        idle();
        settle(); adv();

        // capacity (MAXOUT = 2)
        long_issue_e = 1; rd_e = 4;
        settle(); adv();
        rd_e = 5;
        settle(); adv();
        long_issue_e = 0; rd_e = 0; long_d = 1;
        settle();
        chk_const("cap_full", 64'({outstanding, stall_d}), {61'd0, 2'd2, 1'b1});
        adv();
        long_done = 1; long_rd_done = 4;
        settle(); adv();
        long_done = 0;
        settle();
        chk_const("cap_release", 64'({outstanding, stall_d}), {61'd0, 2'd1, 1'b0});
        adv();
        long_d = 0; long_issue_e = 1; rd_e = 6; long_done = 1; long_rd_done = 5;
        settle(); adv();
        idle();
        settle();
        chk_const("cap_issue_done", 64'(outstanding), 64'd1);
        adv();
        long_done = 1; long_rd_done = 6;
        settle(); adv();
        idle();

        // error: completion for a register that is not pending
        long_done = 1; long_rd_done = 12;
        settle(); adv();
        idle();
        settle();
        chk_const("err_set", 64'({sb_err, outstanding}), {61'd0, 1'b1, 2'd0});
        adv();

        // asynchronous reset in the middle of an op
        long_issue_e = 1; rd_e = 10;
        settle(); adv();
        idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_const("async_rst", 64'({pending, outstanding, sb_err}), 64'd0);
        settle(); adv();
        rst_n = 1'b1;
        settle(); adv();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rs1_d = AW'($urandom_range(0, 15)); rs2_d = AW'($urandom_range(0, 15));
            rd_d = AW'($urandom_range(0, 15)); regwrite_d = $urandom_range(0, 1) == 1;
            long_d = $urandom_range(0, 3) == 0;
            rs1_e = AW'($urandom_range(0, 15)); rs2_e = AW'($urandom_range(0, 15));
            rd_e = AW'($urandom_range(0, 15)); load_e = $urandom_range(0, 3) == 0;
            rd_m = AW'($urandom_range(0, 15)); rd_w = AW'($urandom_range(0, 15));
            regwrite_m = $urandom_range(0, 1) == 1; regwrite_w = $urandom_range(0, 1) == 1;
            pcsrc_e = $urandom_range(0, 9) == 0;
            // Issues only target non-pending registers, because the pipeline never issues a duplicate.
            long_issue_e = ($urandom_range(0, 2) == 0) && !pend_m[rd_e];
            pl.delete();
            for (int i = 1; i < NREG; i++) if (pend_m[i]) pl.push_back(i);
            long_done = $urandom_range(0, 2) == 0;
            if (pl.size() > 0 && $urandom_range(0, 9) < 8)
                long_rd_done = AW'(pl[$urandom_range(0, pl.size() - 1)]);
            else
                long_rd_done = AW'($urandom_range(0, 15));
            settle(); adv();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
